// File: rtl/systolic_mm_engine.sv
// Output-stationary ROWS x COLS systolic matrix-multiply engine: skewed A/B beats
// stream through the PE grid, each PE accumulates its C element, rows drain in order.
module systolic_mm_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_W    = 8,
  parameter int SIGNED = 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [K_W-1:0]          k_len,
  input  logic                    acc_mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  a_vec,
  input  logic [COLS*DATA_W-1:0]  b_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RW-1:0]           out_row,
  output logic [COLS*ACC_W-1:0]   out_data,
  output logic                    busy,
  output logic                    done
);
  localparam int FW = $clog2(ROWS + COLS);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] sa, sb, sp;
    logic        [2*DATA_W-1:0] up;
    sa = {{DATA_W{a[DATA_W-1]}}, a};
    sb = {{DATA_W{b[DATA_W-1]}}, b};
    sp = sa * sb;
    up = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    if (SIGNED != 0) mul_ext = ACC_W'(sp);
    else             mul_ext = ACC_W'(up);
  endfunction

  state_t          state, state_nx;
  logic [K_W-1:0]  k_lat, beat_cnt;
  logic [FW-1:0]   flush_cnt;
  logic [RW-1:0]   row_idx;
  logic            accept, row_take, last_row, clr;

  logic [DATA_W-1:0] a_sk_p0  [ROWS][ROWS];
  logic              vld_a_p0 [ROWS][ROWS];
  logic [DATA_W-1:0] b_sk_p0  [COLS][COLS];
  logic              vld_b_p0 [COLS][COLS];
  logic [DATA_W-1:0] a_pe_p1  [ROWS][COLS];
  logic [DATA_W-1:0] b_pe_p1  [ROWS][COLS];
  logic              vld_a_p1 [ROWS][COLS];
  logic              vld_b_p1 [ROWS][COLS];
  logic [ACC_W-1:0]  acc      [ROWS][COLS];
  logic [DATA_W-1:0] a_l      [ROWS][COLS];
  logic [DATA_W-1:0] b_t      [ROWS][COLS];
  logic              va_l     [ROWS][COLS];
  logic              vb_t     [ROWS][COLS];

  assign accept   = in_valid & in_ready;
  assign row_take = out_valid & out_ready;
  assign last_row = (row_idx == RW'(ROWS - 1));
  assign clr      = (state == IDLE) && start && !acc_mode;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (k_len == '0) ? DRAIN : FEED;
      FEED:    if (accept && (beat_cnt == k_lat - K_W'(1))) state_nx = FLUSH;
      FLUSH:   if (flush_cnt == FW'(ROWS + COLS - 2)) state_nx = DRAIN;
      DRAIN:   if (row_take && last_row) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == FEED);
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    out_row   = row_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_lat     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
      done      <= 1'b0;
    end else begin
      done <= row_take && last_row;
      if ((state == IDLE) && start) k_lat <= k_len;
      if (state != FEED)  beat_cnt <= '0;
      else if (accept)    beat_cnt <= beat_cnt + 1'b1;
      if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
      else                flush_cnt <= '0;
      if (state != DRAIN) row_idx <= '0;
      else if (row_take)  row_idx <= last_row ? '0 : row_idx + 1'b1;
    end
  end

  // p0: skew chains, element i of a_vec delayed i cycles, element j of b_vec delayed j
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int d = 0; d < ROWS; d++) begin
          a_sk_p0[i][d]  <= '0;
          vld_a_p0[i][d] <= 1'b0;
        end
      for (int j = 0; j < COLS; j++)
        for (int d = 0; d < COLS; d++) begin
          b_sk_p0[j][d]  <= '0;
          vld_b_p0[j][d] <= 1'b0;
        end
    end else begin
      for (int i = 0; i < ROWS; i++) begin
        a_sk_p0[i][0]  <= a_vec[i*DATA_W +: DATA_W];
        vld_a_p0[i][0] <= accept;
        for (int d = 1; d < ROWS; d++) begin
          a_sk_p0[i][d]  <= a_sk_p0[i][d-1];
          vld_a_p0[i][d] <= vld_a_p0[i][d-1];
        end
      end
      for (int j = 0; j < COLS; j++) begin
        b_sk_p0[j][0]  <= b_vec[j*DATA_W +: DATA_W];
        vld_b_p0[j][0] <= accept;
        for (int d = 1; d < COLS; d++) begin
          b_sk_p0[j][d]  <= b_sk_p0[j][d-1];
          vld_b_p0[j][d] <= vld_b_p0[j][d-1];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      a_l[i][0]  = a_vec[i*DATA_W +: DATA_W];
      va_l[i][0] = accept;
      for (int j = 1; j < COLS; j++) begin
        a_l[i][j]  = a_pe_p1[i][j-1];
        va_l[i][j] = vld_a_p1[i][j-1];
      end
    end
    for (int i = 1; i < ROWS; i++) begin
      a_l[i][0]  = a_sk_p0[i][i-1];
      va_l[i][0] = vld_a_p0[i][i-1];
    end
    for (int j = 0; j < COLS; j++) begin
      b_t[0][j]  = b_vec[j*DATA_W +: DATA_W];
      vb_t[0][j] = accept;
      for (int i = 1; i < ROWS; i++) begin
        b_t[i][j]  = b_pe_p1[i-1][j];
        vb_t[i][j] = vld_b_p1[i-1][j];
      end
    end
    for (int j = 1; j < COLS; j++) begin
      b_t[0][j]  = b_sk_p0[j][j-1];
      vb_t[0][j] = vld_b_p0[j][j-1];
    end
  end

  // p1: PE grid forwards a right and b down, accumulates only on valid beats
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_pe_p1[i][j]  <= '0;
          b_pe_p1[i][j]  <= '0;
          vld_a_p1[i][j] <= 1'b0;
          vld_b_p1[i][j] <= 1'b0;
          acc[i][j]      <= '0;
        end
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) begin
          a_pe_p1[i][j]  <= a_l[i][j];
          b_pe_p1[i][j]  <= b_t[i][j];
          vld_a_p1[i][j] <= va_l[i][j];
          vld_b_p1[i][j] <= vb_t[i][j];
          if (clr)
            acc[i][j] <= '0;
          else if (va_l[i][j] && vb_t[i][j])
            acc[i][j] <= acc[i][j] + mul_ext(a_l[i][j], b_t[i][j]);
        end
    end
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < COLS; j++)
      out_data[j*ACC_W +: ACC_W] = acc[row_idx][j];
  end
endmodule
